// File: rtl/hazard_pkg.sv
// Shared types and defaults for the decode-stage hazard scoreboard.
package hazard_pkg;

   typedef enum logic [1:0] {
      KIND_ALU  = 2'b00,
      KIND_LOAD = 2'b01,
      KIND_MUL  = 2'b10,
      KIND_DIV  = 2'b11
   } kind_t;

   localparam int unsigned DEFAULT_CNT_W = 4;

   typedef logic [4:0] reg_idx_t;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: fixed-latency countdown plus a divide-pending flag.
module sb_entry #(
   parameter int unsigned CNT_W = hazard_pkg::DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_en,
   input  logic [CNT_W-1:0] load_val,
   input  logic             set_div,
   input  logic             clr_div,
   output logic             busy
);

   logic [CNT_W-1:0] cnt;
   logic             dpend;

   // A new accept overrides the running countdown for this register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt   <= '0;
         dpend <= 1'b0;
      end else begin
         if (load_en) begin
            cnt <= load_val;
         end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
         end
         if (set_div) begin
            dpend <= 1'b1;
         end else if (clr_div) begin
            dpend <= 1'b0;
         end
      end
   end

   assign busy = (cnt != '0) | dpend;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage scoreboard: stalls issue on RAW/WAW against results that
// forwarding cannot yet supply (loads, multiplier, divider).
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int unsigned CNT_W   = DEFAULT_CNT_W,
   parameter int unsigned MUL_LAT = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        issue_valid,
   input  logic [1:0]  issue_kind,
   input  logic        issue_regwrite,
   input  logic [4:0]  issue_rd,
   input  logic [4:0]  issue_rs1,
   input  logic [4:0]  issue_rs2,
   input  logic        issue_use_rs1,
   input  logic        issue_use_rs2,
   input  logic        flush,
   input  logic        div_done,
   input  logic [4:0]  div_rd,
   output logic        stall,
   output logic        div_busy,
   output logic [31:0] busy_mask,
   output logic [5:0]  pending_count
);

   logic [31:0]      busy_v;
   logic [31:0]      dpend_v;
   logic             raw1, raw2, waw, divc;
   logic             accept;
   kind_t            kind;
   reg_idx_t         rd;
   logic [CNT_W-1:0] load_val;

   assign kind = kind_t'(issue_kind);
   assign rd   = reg_idx_t'(issue_rd);

   // Hazard detection is purely combinational from ID inputs and state.
   assign raw1   = issue_use_rs1 & busy_v[issue_rs1];
   assign raw2   = issue_use_rs2 & busy_v[issue_rs2];
   assign waw    = issue_regwrite & busy_v[issue_rd];
   assign divc   = (kind == KIND_DIV) & div_busy;
   assign stall  = issue_valid & ~flush & (raw1 | raw2 | waw | divc);
   assign accept = issue_valid & ~flush & ~stall & issue_regwrite & (rd != 5'd0);

   assign load_val = (kind == KIND_LOAD) ? CNT_W'(1) : CNT_W'(MUL_LAT - 1);

   assign busy_v[0]  = 1'b0;
   assign dpend_v[0] = 1'b0;

   for (genvar r = 1; r < 32; r++) begin : g_entry
      logic hit;
      assign hit        = accept & (rd == 5'(r));
      assign dpend_v[r] = hit & (kind == KIND_DIV);
      sb_entry #(.CNT_W(CNT_W)) u_entry (
         .clk      (clk),
         .rst_n    (rst_n),
         .load_en  (hit & ((kind == KIND_LOAD) | (kind == KIND_MUL))),
         .load_val (load_val),
         .set_div  (dpend_v[r]),
         .clr_div  (div_done & (div_rd == 5'(r))),
         .busy     (busy_v[r])
      );
   end

   // Only one divide can be outstanding, so tracking the owner register
   // is enough to derive div_busy from registered state.
   logic [31:0] div_owner;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_owner <= '0;
      end else begin
         for (int i = 1; i < 32; i++) begin
            if (dpend_v[i]) begin
               div_owner[i] <= 1'b1;
            end else if (div_done && (div_rd == 5'(i))) begin
               div_owner[i] <= 1'b0;
            end
         end
      end
   end

   assign div_busy  = |div_owner;
   assign busy_mask = busy_v;

   always_comb begin
      pending_count = '0;
      for (int i = 0; i < 32; i++) begin
         pending_count = pending_count + 6'(busy_v[i]);
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (MUL_LAT = 3).
module tb_hazard_scoreboard;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        issue_valid;
   logic [1:0]  issue_kind;
   logic        issue_regwrite;
   logic [4:0]  issue_rd;
   logic [4:0]  issue_rs1;
   logic [4:0]  issue_rs2;
   logic        issue_use_rs1;
   logic        issue_use_rs2;
   logic        flush;
   logic        div_done;
   logic [4:0]  div_rd;
   logic        stall;
   logic        div_busy;
   logic [31:0] busy_mask;
   logic [5:0]  pending_count;

   int tests_run  = 0;
   int fail_count = 0;

   hazard_scoreboard #(.CNT_W(4), .MUL_LAT(3)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .issue_valid    (issue_valid),
      .issue_kind     (issue_kind),
      .issue_regwrite (issue_regwrite),
      .issue_rd       (issue_rd),
      .issue_rs1      (issue_rs1),
      .issue_rs2      (issue_rs2),
      .issue_use_rs1  (issue_use_rs1),
      .issue_use_rs2  (issue_use_rs2),
      .flush          (flush),
      .div_done       (div_done),
      .div_rd         (div_rd),
      .stall          (stall),
      .div_busy       (div_busy),
      .busy_mask      (busy_mask),
      .pending_count  (pending_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue_valid    = 1'b0;
      issue_kind     = 2'b00;
      issue_regwrite = 1'b0;
      issue_rd       = 5'd0;
      issue_rs1      = 5'd0;
      issue_rs2      = 5'd0;
      issue_use_rs1  = 1'b0;
      issue_use_rs2  = 1'b0;
      flush          = 1'b0;
      div_done       = 1'b0;
      div_rd         = 5'd0;
   endtask

   task automatic drive(input logic [1:0] kind, input logic wr, input logic [4:0] rd,
                        input logic use1, input logic [4:0] rs1);
      issue_valid    = 1'b1;
      issue_kind     = kind;
      issue_regwrite = wr;
      issue_rd       = rd;
      issue_use_rs1  = use1;
      issue_rs1      = rs1;
      issue_use_rs2  = 1'b0;
      issue_rs2      = 5'd0;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      cycle();
      cycle();
      rst_n = 1'b1;
      tests_run++;
      if (stall !== 1'b0 || div_busy !== 1'b0 || busy_mask !== 32'h0 || pending_count !== 6'd0) begin
         fail_count++;
         $display("FAIL reset: stall=%b div_busy=%b mask=%h pend=%0d, required 0 0 0 0",
                  stall, div_busy, busy_mask, pending_count);
      end
   endtask

   task automatic test_load_use();
      drive(2'b01, 1'b1, 5'd5, 1'b0, 5'd0);
      #1;
      tests_run++;
      if (stall !== 1'b0) begin
         fail_count++;
         $display("FAIL load_accept_stall: got %b, required 0", stall);
      end
      cycle();
      drive(2'b00, 1'b1, 5'd6, 1'b1, 5'd5);
      #1;
      tests_run++;
      if (stall !== 1'b1 || busy_mask !== 32'h20 || pending_count !== 6'd1) begin
         fail_count++;
         $display("FAIL load_use_stall: stall=%b mask=%h pend=%0d, required 1 00000020 1",
                  stall, busy_mask, pending_count);
      end
      cycle();
      tests_run++;
      if (stall !== 1'b0 || busy_mask !== 32'h0 || pending_count !== 6'd0) begin
         fail_count++;
         $display("FAIL load_use_release: stall=%b mask=%h pend=%0d, required 0 0 0",
                  stall, busy_mask, pending_count);
      end
      cycle();
      idle();
   endtask

   task automatic test_mul_raw();
      int n = 0;
      drive(2'b10, 1'b1, 5'd7, 1'b0, 5'd0);
      cycle();
      drive(2'b00, 1'b1, 5'd11, 1'b1, 5'd7);
      for (int i = 0; i < 10; i++) begin
         #1;
         if (stall !== 1'b1) break;
         n++;
         cycle();
      end
      tests_run++;
      if (n !== 2) begin
         fail_count++;
         $display("FAIL mul_raw_stall_cycles: got %0d, required 2", n);
      end
      cycle();
      drive(2'b10, 1'b1, 5'd7, 1'b0, 5'd0);
      cycle();
      drive(2'b00, 1'b1, 5'd8, 1'b1, 5'd8);
      #1;
      tests_run++;
      if (stall !== 1'b0 || busy_mask !== 32'h80) begin
         fail_count++;
         $display("FAIL mul_independent: stall=%b mask=%h, required 0 00000080", stall, busy_mask);
      end
      cycle();
      idle();
      cycle();
      tests_run++;
      if (busy_mask !== 32'h0) begin
         fail_count++;
         $display("FAIL mul_drain: mask=%h, required 0", busy_mask);
      end
   endtask

   task automatic test_divide();
      drive(2'b11, 1'b1, 5'd9, 1'b0, 5'd0);
      cycle();
      drive(2'b11, 1'b1, 5'd10, 1'b0, 5'd0);
      #1;
      tests_run++;
      if (stall !== 1'b1 || div_busy !== 1'b1 || busy_mask !== 32'h200) begin
         fail_count++;
         $display("FAIL div_second_stall: stall=%b div_busy=%b mask=%h, required 1 1 00000200",
                  stall, div_busy, busy_mask);
      end
      cycle();
      // Reader of x9 that also starts a load to x12, in the div_done cycle.
      drive(2'b01, 1'b1, 5'd12, 1'b1, 5'd9);
      div_done = 1'b1;
      div_rd   = 5'd9;
      #1;
      tests_run++;
      if (stall !== 1'b1) begin
         fail_count++;
         $display("FAIL div_done_same_cycle: stall=%b, required 1", stall);
      end
      cycle();
      div_done = 1'b0;
      div_rd   = 5'd0;
      #1;
      tests_run++;
      if (stall !== 1'b0 || div_busy !== 1'b0 || busy_mask !== 32'h0) begin
         fail_count++;
         $display("FAIL div_release: stall=%b div_busy=%b mask=%h, required 0 0 0",
                  stall, div_busy, busy_mask);
      end
      cycle();
      idle();
      tests_run++;
      if (busy_mask !== 32'h1000 || pending_count !== 6'd1) begin
         fail_count++;
         $display("FAIL div_then_load: mask=%h pend=%0d, required 00001000 1", busy_mask, pending_count);
      end
      cycle();
   endtask

   task automatic test_waw_x0();
      drive(2'b01, 1'b1, 5'd3, 1'b0, 5'd0);
      cycle();
      drive(2'b00, 1'b1, 5'd3, 1'b0, 5'd0);
      #1;
      tests_run++;
      if (stall !== 1'b1) begin
         fail_count++;
         $display("FAIL waw_stall: stall=%b, required 1", stall);
      end
      cycle();
      tests_run++;
      if (stall !== 1'b0) begin
         fail_count++;
         $display("FAIL waw_release: stall=%b, required 0", stall);
      end
      cycle();
      drive(2'b01, 1'b1, 5'd0, 1'b0, 5'd0);
      cycle();
      drive(2'b10, 1'b1, 5'd0, 1'b1, 5'd0);
      #1;
      tests_run++;
      if (stall !== 1'b0 || busy_mask !== 32'h0 || pending_count !== 6'd0) begin
         fail_count++;
         $display("FAIL x0_never_busy: stall=%b mask=%h pend=%0d, required 0 0 0",
                  stall, busy_mask, pending_count);
      end
      cycle();
      idle();
      tests_run++;
      if (busy_mask !== 32'h0) begin
         fail_count++;
         $display("FAIL x0_mul_write: mask=%h, required 0", busy_mask);
      end
   endtask

   task automatic test_flush();
      drive(2'b10, 1'b1, 5'd5, 1'b0, 5'd0);
      cycle();
      drive(2'b01, 1'b1, 5'd6, 1'b1, 5'd5);
      flush = 1'b1;
      #1;
      tests_run++;
      if (stall !== 1'b0) begin
         fail_count++;
         $display("FAIL flush_stall: stall=%b, required 0", stall);
      end
      cycle();
      idle();
      tests_run++;
      if (busy_mask !== 32'h20) begin
         fail_count++;
         $display("FAIL flush_no_accept: mask=%h, required 00000020", busy_mask);
      end
      cycle();
      tests_run++;
      if (busy_mask !== 32'h0) begin
         fail_count++;
         $display("FAIL flush_keeps_counting: mask=%h, required 0", busy_mask);
      end
   endtask

   task automatic test_reset_mid_div();
      drive(2'b11, 1'b1, 5'd9, 1'b0, 5'd0);
      cycle();
      idle();
      tests_run++;
      if (div_busy !== 1'b1) begin
         fail_count++;
         $display("FAIL rst_div_pending: div_busy=%b, required 1", div_busy);
      end
      rst_n = 1'b0;
      cycle();
      drive(2'b00, 1'b1, 5'd1, 1'b1, 5'd9);
      #1;
      tests_run++;
      if (stall !== 1'b0 || div_busy !== 1'b0 || busy_mask !== 32'h0 || pending_count !== 6'd0) begin
         fail_count++;
         $display("FAIL rst_mid_div: stall=%b div_busy=%b mask=%h pend=%0d, required 0 0 0 0",
                  stall, div_busy, busy_mask, pending_count);
      end
      idle();
      rst_n    = 1'b1;
      div_done = 1'b1;
      div_rd   = 5'd9;
      cycle();
      idle();
      drive(2'b11, 1'b1, 5'd9, 1'b0, 5'd0);
      #1;
      tests_run++;
      if (stall !== 1'b0 || div_busy !== 1'b0 || busy_mask !== 32'h0) begin
         fail_count++;
         $display("FAIL rst_stray_done: stall=%b div_busy=%b mask=%h, required 0 0 0",
                  stall, div_busy, busy_mask);
      end
      cycle();
      idle();
      tests_run++;
      if (div_busy !== 1'b1 || busy_mask !== 32'h200) begin
         fail_count++;
         $display("FAIL rst_div_reissue: div_busy=%b mask=%h, required 1 00000200", div_busy, busy_mask);
      end
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      #1;
      test_reset();
      test_load_use();
      test_mul_raw();
      test_divide();
      test_waw_x0();
      test_flush();
      test_reset_mid_div();
      $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

- Per-register scoreboard in the decode stage of the 5-stage pipeline.
- Tracks which destination registers have results not yet forwardable: loads, the fixed-latency multiplier and the variable-latency divider.
- Stalls issue on RAW hazards (read a busy register) and WAW hazards (write a busy register).
- Complements the EX/MEM and MEM/WB forwarding path: it covers the hazards forwarding cannot resolve and stalls until forwarding or the register file can supply the value.

## Interface

Parameters:
- `CNT_W`, default 4: width of the per-register countdown counter.
- `MUL_LAT`, default 3: EX cycles before a multiply result reaches EX/MEM. Legal range 2 to 2^CNT_W.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `issue_valid`  in  1  ID holds a valid instruction.
- `issue_kind`  in  2  result source: 00 ALU, 01 LOAD, 10 MUL, 11 DIV.
- `issue_regwrite`  in  1  instruction writes `issue_rd`.
- `issue_rd`  in  5  destination register.
- `issue_rs1`, `issue_rs2`  in  5 each  source registers.
- `issue_use_rs1`, `issue_use_rs2`  in  1 each  source register is actually read.
- `flush`  in  1  ID instruction is squashed this cycle.
- `div_done`  in  1  divider writes back this cycle.
- `div_rd`  in  5  divider destination register.
- `stall`  out  1  hold PC and IF/ID; insert a bubble into ID/EX.
- `div_busy`  out  1  a divide is in flight.
- `busy_mask`  out  32  bit r = register r is busy; bit 0 is always 0.
- `pending_count`  out  6  popcount of `busy_mask`.

## Operation

State:
- Registers 1..31 each have `cnt[r]` (CNT_W bits) and `dpend[r]` (1 bit).
- `busy(r) = (cnt[r] != 0) | dpend[r]`.
- Register 0 is never busy.

Stall (combinational from state and the ID inputs):
- `stall = issue_valid & ~flush & (raw1 | raw2 | waw | divc)`.
- `raw1 = issue_use_rs1 & busy(issue_rs1)`; `raw2` likewise for rs2.
- `waw = issue_regwrite & busy(issue_rd)`.
- `divc = (issue_kind == DIV) & div_busy`. Only one divide may be in flight.

Accept and state update:
- Accept condition: `issue_valid & ~flush & ~stall & issue_regwrite & issue_rd != 0`.
- ALU accept: no state change. Normal forwarding covers it.
- LOAD accept: `cnt[rd] <= 1`. This is the one-bubble load-use delay.
- MUL accept: `cnt[rd] <= MUL_LAT - 1`.
- DIV accept: `dpend[rd] <= 1`.
- Every other nonzero `cnt` decrements by 1 each cycle, saturating at 0. An accept to register r overrides that register's decrement.
- `div_done` with `div_rd != 0`: `dpend[div_rd] <= 0`. If `div_done` is asserted while `dpend[div_rd]` is 0, or `div_rd` is 0, nothing happens.
- Outputs: `div_busy` is the OR of all `dpend`; `busy_mask` is `{busy(31..1), 1'b0}`.

Boundary rules:
- **`flush` with `issue_valid`:** forces `stall = 0` and no accept. In-flight entries keep counting.
- **`div_done` for r while ID reads r:** `stall` is still 1 in that cycle. It drops the next cycle, when the value is available from MEM/WB forwarding.
- **Accept and `div_done` in the same cycle:** cannot target the same register, because WAW stalls the accept. Both take effect for different registers.
- **Reset mid-operation:** clears everything, including an in-flight divide. The pipeline must discard the divider result.

## Timing

- On reset, the next edge sets all `cnt` and `dpend` to 0, `stall` 0, `div_busy` 0, `busy_mask` 0, `pending_count` 0.
- `stall` has zero latency: same-cycle combinational from the ID inputs and registered state.
- State updates on the rising edge of `clk`.
- LOAD followed immediately by a dependent instruction: exactly one stall cycle.
- MUL followed immediately by a dependent instruction: exactly `MUL_LAT - 1` stall cycles.
- DIV followed by a dependent instruction: stall through the cycle `div_done` is asserted; issue proceeds in the following cycle.
- `busy_mask` and `pending_count` reflect state after the last edge. There is no combinational path from the issue inputs to either.

## Structure

- `hazard_pkg` holds:
  - the `kind_t` enum: ALU, LOAD, MUL, DIV;
  - a default `CNT_W` localparam;
  - a register-index typedef of 5 bits.
- Sub-module `sb_entry`, instantiated for registers 1..31 with a generate loop, holds:
  - one counter and one `dpend` bit;
  - inputs: load value, set-div, clear-div;
  - output: busy.
- Top level contains the stall logic, the `div_busy` OR-reduce and the popcount.

## Test plan

- **Load-use:** LOAD x5 accepted, next cycle ID reads x5 (`use_rs1`).
  - Required: `stall = 1` for 1 cycle, `busy_mask[5] = 1` then 0.
  - Required: `pending_count` goes 1 → 0.
- **Multiply RAW:** MUL x7 with `MUL_LAT = 3`, dependent instruction follows.
  - Required: `stall` for exactly 2 cycles.
  - An independent instruction using x8 issues with no stall.
- **Divide:** DIV x9, then DIV x10.
  - Required: second DIV stalls via `div_busy`.
  - `div_done` with `div_rd = 9` → stall drops the next cycle; `dpend[9]` clears.
- **WAW:** LOAD x3, then ALU write to x3 → 1 stall cycle. Writes to x0 never set busy, and reading x0 never stalls.
- **Flush:** `flush` asserted with a dependent read of busy x5 → `stall = 0`, no state change, `cnt[5]` still decrements.
- **Reset mid-divide:** `rst_n` low with `dpend[9] = 1` → next edge: all outputs 0; a later stray `div_done` is ignored.
